serial_eq_arbiter: RTL

Shared bit-serial equality engine with a two-port round-robin arbiter. Two requesters each present a pair of WIDTH-bit operands. The block grants one requester, latches its operands, and compares them LSB-first with a single 1-bit equality cell, one bit per cycle. It exits early on the first differing bit and returns equal/not-equal plus the index of the first difference. It sits between the compare clients and the single equality cell, replacing per-client wide comparators.

---
 rtl/serial_eq_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_eq_arbiter.sv
// Shared bit-serial equality engine: two requesters, round-robin arbitration,
// LSB-first compare through a single 1-bit equality cell with early exit.
module serial_eq_arbiter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             owner,
  output logic [CW-1:0]    diff_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The one shared 1-bit equality cell.
  function automatic logic eq_cell(input logic x, input logic y);
    return ~(x ^ y);
  endfunction

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             eq_q, eq_d, owner_q, owner_d;
  logic [CW-1:0]    diff_q, diff_d;
  logic             win;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      owner_q <= 1'b0;
      diff_q  <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      owner_q <= owner_d;
      diff_q  <= diff_d;
    end
  end

  // Next-state, arbitration and compare step; result fields hold until the next DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    eq_d    = eq_q;
    owner_d = owner_q;
    diff_d  = diff_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win     = (req0 && req1) ? ~last_q : req1;
          sa_d    = win ? a1 : a0;
          sb_d    = win ? b1 : b0;
          cnt_d   = {CW{1'b0}};
          sel_d   = win;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (!eq_cell(sa_q[0], sb_q[0])) begin
          state_d = DONE;
          done_d  = 1'b1;
          eq_d    = 1'b0;
          owner_d = sel_q;
          diff_d  = cnt_q;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          eq_d    = 1'b1;
          owner_d = sel_q;
          diff_d  = {CW{1'b0}};
        end else begin
          sa_d  = {1'b0, sa_q[WIDTH-1:1]};
          sb_d  = {1'b0, sb_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign eq       = eq_q;
  assign owner    = owner_q;
  assign diff_idx = diff_q;

endmodule
